// File: rtl/mj_mode_sequencer_pkg.sv
// Shared types for the mode sequencer: FSM state enum, display mode codes,
// switch mode codes and state-to-indicator decode helpers.
package mj_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_ADDR,
        ST_WR_DATA,
        ST_RD_ADDR,
        ST_RD_WAIT,
        ST_RD_SHOW
    } mj_state_e;

    localparam logic [2:0] DISP_IDLE  = 3'd0;
    localparam logic [2:0] DISP_ENTRY = 3'd3;
    localparam logic [2:0] DISP_READ  = 3'd6;

    localparam logic [2:0] MODE_WR = 3'd2;
    localparam logic [2:0] MODE_RD = 3'd3;

    // RD_WAIT is a single internal cycle; it keeps showing the read-address indication.
    function automatic logic [7:0] ledg_of(input mj_state_e s);
        case (s)
            ST_IDLE:    ledg_of = 8'h01;
            ST_WR_ADDR: ledg_of = 8'h02;
            ST_WR_DATA: ledg_of = 8'h04;
            ST_RD_ADDR: ledg_of = 8'h08;
            ST_RD_WAIT: ledg_of = 8'h08;
            ST_RD_SHOW: ledg_of = 8'h10;
            default:    ledg_of = 8'h01;
        endcase
    endfunction

    function automatic logic [2:0] disp_of(input mj_state_e s);
        case (s)
            ST_IDLE:    disp_of = DISP_IDLE;
            ST_RD_SHOW: disp_of = DISP_READ;
            default:    disp_of = DISP_ENTRY;
        endcase
    endfunction

endpackage

// File: rtl/mj_mode_sequencer_if.sv
// RAM strobe/address/data bus between the mode sequencer (master) and the RAM (slave).
interface mj_mode_sequencer_if #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 16
);
    logic              ram_we;
    logic              ram_re;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    modport master (
        output ram_we,
        output ram_re,
        output ram_addr,
        output ram_wdata,
        input  ram_rdata
    );

    modport slave (
        input  ram_we,
        input  ram_re,
        input  ram_addr,
        input  ram_wdata,
        output ram_rdata
    );
endinterface

// File: rtl/mj_mode_sequencer_key_pulse.sv
// Enter-key conditioning: two-flop synchroniser, optional debounce (MJ_DEBOUNCE_EN)
// and rising-edge detector producing a single-cycle pulse per key press.
module mj_key_pulse #(
    parameter int unsigned DEB_CYC = 1000000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic key_i,
    output logic pulse_o
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;
    logic level;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= key_i;
            sync2_q <= sync1_q;
        end
    end

`ifdef MJ_DEBOUNCE_EN
    localparam int unsigned DEB_W = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;

    logic [DEB_W-1:0] deb_cnt_q;
    logic             stable_q;

    // The accepted level only flips after the synchronised key differs for DEB_CYC cycles in a row.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            deb_cnt_q <= '0;
            stable_q  <= 1'b0;
        end else if (sync2_q == stable_q) begin
            deb_cnt_q <= '0;
        end else if (deb_cnt_q == DEB_W'(DEB_CYC - 1)) begin
            deb_cnt_q <= '0;
            stable_q  <= sync2_q;
        end else begin
            deb_cnt_q <= deb_cnt_q + 1'b1;
        end
    end

    assign level = stable_q;
`else
    assign level = sync2_q;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= level;
        end
    end

    assign pulse_o = level & ~prev_q;

endmodule

// File: rtl/mj_mode_sequencer.sv
// Switch/enter-key driven RAM write/read sequencer with 7-segment mode and LED state outputs.
// Define MJ_DEBOUNCE_EN to debounce the enter key before edge detection.
module mj_mode_sequencer
    import mj_pkg::*;
#(
    parameter int unsigned ADDR_W      = 4,
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned TIMEOUT_CYC = 500000000,
    parameter int unsigned DEB_CYC     = 1000000
) (
    input  logic                     clk_50M,
    input  logic                     rst,
    input  logic                     enter,
    input  logic [9:0]               sw,
    mj_mode_sequencer_if.master      ram,
    output logic [2:0]               disp_sel,
    output logic [DATA_W-1:0]        disp_val,
    output logic [7:0]               ledg
);

    localparam int unsigned CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(TIMEOUT_CYC - 1);

    logic enp;

    mj_key_pulse #(
        .DEB_CYC (DEB_CYC)
    ) u_key (
        .clk_i   (clk_50M),
        .rst_i   (rst),
        .key_i   (enter),
        .pulse_o (enp)
    );

    mj_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ram_we_q, ram_re_q;
    logic              we_d, re_d, addr_ld;
    logic [ADDR_W-1:0] ram_addr_q;
    logic [DATA_W-1:0] ram_wdata_q;
    logic [DATA_W-1:0] disp_val_q;
    logic [2:0]        disp_sel_q;
    logic [7:0]        ledg_q;
    logic              timed;
    logic              timeout;

    always_comb begin
        timed = (state_q == ST_WR_ADDR) || (state_q == ST_WR_DATA) ||
                (state_q == ST_RD_ADDR) || (state_q == ST_RD_SHOW);
        timeout = timed && (cnt_q == CNT_LIM);
        state_d = state_q;
        we_d    = 1'b0;
        re_d    = 1'b0;
        addr_ld = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (enp) begin
                    if (sw[2:0] == MODE_WR)      state_d = ST_WR_ADDR;
                    else if (sw[2:0] == MODE_RD) state_d = ST_RD_ADDR;
                end
            end
            ST_WR_ADDR: begin
                if (enp) begin
                    addr_ld = 1'b1;
                    state_d = ST_WR_DATA;
                end else if (timeout) begin
                    state_d = ST_IDLE;
                end
            end
            ST_WR_DATA: begin
                if (enp) begin
                    we_d    = 1'b1;
                    state_d = ST_IDLE;
                end else if (timeout) begin
                    state_d = ST_IDLE;
                end
            end
            ST_RD_ADDR: begin
                // Stay here while the read strobe is out so RD_WAIT lines up with valid read data.
                if (ram_re_q) begin
                    state_d = ST_RD_WAIT;
                end else if (enp) begin
                    addr_ld = 1'b1;
                    re_d    = 1'b1;
                end else if (timeout) begin
                    state_d = ST_IDLE;
                end
            end
            ST_RD_WAIT: state_d = ST_RD_SHOW;
            ST_RD_SHOW: begin
                if (enp || timeout) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (enp || (state_d != state_q)) begin
            cnt_d = '0;
        end else if (timed && (cnt_q != CNT_LIM)) begin
            cnt_d = cnt_q + 1'b1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    always_ff @(posedge clk_50M or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            ram_we_q    <= 1'b0;
            ram_re_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            disp_val_q  <= '0;
            disp_sel_q  <= DISP_IDLE;
            ledg_q      <= 8'h01;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ram_we_q   <= we_d;
            ram_re_q   <= re_d;
            disp_sel_q <= disp_of(state_d);
            ledg_q     <= ledg_of(state_d);
            if (addr_ld) ram_addr_q <= sw[ADDR_W-1:0];
            if (we_d) ram_wdata_q <= DATA_W'(sw);
            if (state_q == ST_RD_WAIT) disp_val_q <= ram.ram_rdata;
        end
    end

    assign ram.ram_we    = ram_we_q;
    assign ram.ram_re    = ram_re_q;
    assign ram.ram_addr  = ram_addr_q;
    assign ram.ram_wdata = ram_wdata_q;
    assign disp_sel      = disp_sel_q;
    assign disp_val      = disp_val_q;
    assign ledg          = ledg_q;

endmodule

// File: tb/tb_mj_mode_sequencer.sv
// Scoreboard bench for mj_mode_sequencer: directed key/switch sequences push expected
// RAM transactions into queues; a monitor pops and checks them as strobes appear.
module tb_mj_mode_sequencer;

    logic        clk_50M = 1'b0;
    logic        rst     = 1'b1;
    logic        enter   = 1'b0;
    logic [9:0]  sw      = '0;
    logic [2:0]  disp_sel;
    logic [15:0] disp_val;
    logic [7:0]  ledg;

    int total = 0;
    int bad   = 0;
    int overlap_cnt = 0;

    typedef struct packed {
        logic [3:0]  addr;
        logic [15:0] data;
    } txn_t;

    txn_t wr_q[$];
    txn_t rd_q[$];

    logic [15:0] mem [16];
    logic        bd_we   = 1'b0;
    logic [3:0]  bd_addr = '0;
    logic [15:0] bd_data = '0;

    mj_mode_sequencer_if #(.ADDR_W(4), .DATA_W(16)) ram_bus ();

    mj_mode_sequencer #(
        .ADDR_W      (4),
        .DATA_W      (16),
        .TIMEOUT_CYC (20),
        .DEB_CYC     (4)
    ) dut (
        .clk_50M  (clk_50M),
        .rst      (rst),
        .enter    (enter),
        .sw       (sw),
        .ram      (ram_bus.master),
        .disp_sel (disp_sel),
        .disp_val (disp_val),
        .ledg     (ledg)
    );

    always #5 clk_50M = ~clk_50M;

    // Synchronous RAM model: read data appears the cycle after the strobe.
    always @(posedge clk_50M) begin
        if (bd_we) mem[bd_addr] <= bd_data;
        if (ram_bus.ram_we) mem[ram_bus.ram_addr] <= ram_bus.ram_wdata;
        if (ram_bus.ram_re) ram_bus.ram_rdata <= mem[ram_bus.ram_addr];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    always @(negedge clk_50M) begin
        if (ram_bus.ram_we && ram_bus.ram_re) overlap_cnt++;
        if (ledg[7:5] != 3'b000) overlap_cnt++;
    end

    // Monitor: every strobe must match the oldest pending expectation.
    always @(negedge clk_50M) begin
        if (ram_bus.ram_we) begin
            chk("we_expected", 32'(wr_q.size() != 0), 32'd1);
            if (wr_q.size() != 0) begin
                txn_t t;
                t = wr_q.pop_front();
                chk("wr_addr", 32'(ram_bus.ram_addr), 32'(t.addr));
                chk("wr_data", 32'(ram_bus.ram_wdata), 32'(t.data));
            end
        end
        if (ram_bus.ram_re) begin
            chk("re_expected", 32'(rd_q.size() != 0), 32'd1);
            if (rd_q.size() != 0) begin
                txn_t t;
                t = rd_q.pop_front();
                chk("rd_addr", 32'(ram_bus.ram_addr), 32'(t.addr));
                repeat (2) @(negedge clk_50M);
                chk("rd_disp_val", 32'(disp_val), 32'(t.data));
                chk("rd_disp_sel", 32'(disp_sel), 32'd6);
                chk("rd_ledg", 32'(ledg), 32'h10);
            end
        end
    end

    task automatic press(input logic [9:0] v);
        @(negedge clk_50M);
        sw    = v;
        enter = 1'b1;
        repeat (4) @(negedge clk_50M);
        enter = 1'b0;
        repeat (4) @(negedge clk_50M);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [9:0] inv_codes [4];
        int         saw_wr_addr;
        int         saw_wr_data;
        inv_codes[0] = 10'd7;
        inv_codes[1] = 10'd0;
        inv_codes[2] = 10'd1;
        inv_codes[3] = 10'd4;

        repeat (3) @(negedge clk_50M);
        chk("rst_ledg", 32'(ledg), 32'h01);
        chk("rst_disp_sel", 32'(disp_sel), 32'd0);
        chk("rst_disp_val", 32'(disp_val), 32'd0);
        chk("rst_we_re", 32'({ram_bus.ram_we, ram_bus.ram_re}), 32'd0);
        chk("rst_addr", 32'(ram_bus.ram_addr), 32'd0);
        chk("rst_wdata", 32'(ram_bus.ram_wdata), 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk_50M);

        // Write 0x2A5 to address 5.
        press(10'd2);
        chk("wr_addr_state_ledg", 32'(ledg), 32'h02);
        chk("wr_addr_disp_sel", 32'(disp_sel), 32'd3);
        press(10'd5);
        chk("wr_data_state_ledg", 32'(ledg), 32'h04);
        wr_q.push_back('{addr: 4'd5, data: 16'h02A5});
        press(10'h2A5);
        chk("wr_done_ledg", 32'(ledg), 32'h01);
        chk("wr_done_addr", 32'(ram_bus.ram_addr), 32'd5);
        chk("wr_done_wdata", 32'(ram_bus.ram_wdata), 32'h02A5);

        // Write 0x3FF to address 9, then read it back through the RAM model.
        press(10'd2);
        press(10'd9);
        wr_q.push_back('{addr: 4'd9, data: 16'h03FF});
        press(10'h3FF);
        press(10'd3);
        chk("rd_addr_state_ledg", 32'(ledg), 32'h08);
        rd_q.push_back('{addr: 4'd9, data: 16'h03FF});
        press(10'd9);
        press(10'd0);

        // Backdoor preload address 5 = 0x1234, then read.
        @(negedge clk_50M);
        bd_addr = 4'd5;
        bd_data = 16'h1234;
        bd_we   = 1'b1;
        @(negedge clk_50M);
        bd_we   = 1'b0;
        press(10'd3);
        rd_q.push_back('{addr: 4'd5, data: 16'h1234});
        press(10'd5);
        chk("show_ledg", 32'(ledg), 32'h10);
        press(10'd0);
        chk("show_exit_ledg", 32'(ledg), 32'h01);
        chk("show_exit_disp_sel", 32'(disp_sel), 32'd0);
        chk("show_exit_disp_val_kept", 32'(disp_val), 32'h1234);

        // Invalid mode codes leave the sequencer idle.
        foreach (inv_codes[i]) begin
            press(inv_codes[i]);
            chk("invalid_mode_ledg", 32'(ledg), 32'h01);
        end

        // Timeout out of WR_DATA without a write.
        press(10'd2);
        press(10'd6);
        chk("to_entry_ledg", 32'(ledg), 32'h04);
        repeat (8) @(negedge clk_50M);
        chk("to_before_ledg", 32'(ledg), 32'h04);
        repeat (10) @(negedge clk_50M);
        chk("to_after_ledg", 32'(ledg), 32'h01);

        // Held key: one transition to WR_ADDR, then timeout back to IDLE.
        @(negedge clk_50M);
        sw          = 10'd2;
        enter       = 1'b1;
        saw_wr_addr = 0;
        saw_wr_data = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk_50M);
            if (ledg == 8'h02) saw_wr_addr = 1;
            if (ledg == 8'h04) saw_wr_data = 1;
        end
        enter = 1'b0;
        repeat (4) @(negedge clk_50M);
        chk("held_saw_wr_addr", 32'(saw_wr_addr), 32'd1);
        chk("held_no_wr_data", 32'(saw_wr_data), 32'd0);
        chk("held_final_ledg", 32'(ledg), 32'h01);

        // Reset asserted on the enp cycle in WR_DATA: no write may follow.
        press(10'd2);
        press(10'd11);
        chk("rm_wr_data_ledg", 32'(ledg), 32'h04);
        @(negedge clk_50M);
        sw    = 10'h155;
        enter = 1'b1;
        repeat (2) @(negedge clk_50M);
        rst = 1'b1;
        #1;
        chk("rm_we_async", 32'(ram_bus.ram_we), 32'd0);
        chk("rm_ledg_async", 32'(ledg), 32'h01);
        @(negedge clk_50M);
        chk("rm_we_next", 32'(ram_bus.ram_we), 32'd0);
        chk("rm_wdata", 32'(ram_bus.ram_wdata), 32'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk_50M);
        enter = 1'b0;
        repeat (10) @(negedge clk_50M);
        chk("rm_final_ledg", 32'(ledg), 32'h01);
        chk("rm_mem11_untouched", 32'(mem[11] === 16'h0155), 32'd0);

        repeat (5) @(negedge clk_50M);
        chk("wr_queue_drained", 32'(wr_q.size()), 32'd0);
        chk("rd_queue_drained", 32'(rd_q.size()), 32'd0);
        chk("no_overlap_or_ledg_hi", 32'(overlap_cnt), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
